// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_timing_pkg : 640x480@60 raster constants and state encoding   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package vga_timing_pkg;

    localparam int c_CNT_W     = 10;

    localparam int c_H_DISPLAY = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_H_TOTAL   = c_H_DISPLAY + c_H_FRONT + c_H_SYNC + c_H_BACK;

    localparam int c_V_DISPLAY = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;
    localparam int c_V_TOTAL   = c_V_DISPLAY + c_V_FRONT + c_V_SYNC + c_V_BACK;

    localparam int              c_ST_W     = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_RUN   = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pix_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pix_tick_gen : divides Clk into a one-cycle pixel-enable pulse    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pix_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_pix_tick
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    logic [c_DIV_W-1:0] r_div;

    // Tick is registered from the current count, so the first pulse lands
    // CLK_DIV cycles after run is first asserted.
    always_ff @(posedge Clk) begin
        if (!Rst || i_clear) begin
            r_div      <= '0;
            o_pix_tick <= 1'b0;
        end else if (i_run) begin
            o_pix_tick <= (r_div == c_DIV_LAST);
            r_div      <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_ONE;
        end else begin
            o_pix_tick <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_timing_ctrl : single-clock VGA raster sequencer with a        |
// |                   frame-aligned Enable/Busy stop handshake        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = c_H_DISPLAY,
    parameter int H_FRONT   = c_H_FRONT,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BACK    = c_H_BACK,
    parameter int V_DISPLAY = c_V_DISPLAY,
    parameter int V_FRONT   = c_V_FRONT,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BACK    = c_V_BACK
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Enable,
    output logic               Busy,
    output logic               Pix_tick,
    output logic [c_CNT_W-1:0] Pix_x,
    output logic [c_CNT_W-1:0] Pix_y,
    output logic               HSync,
    output logic               VSync,
    output logic               Video_on,
    output logic               Frame_start
);

    localparam int c_H_TOT  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOT  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int c_HS_BEG = H_DISPLAY + H_FRONT;
    localparam int c_HS_END = c_HS_BEG + H_SYNC;
    localparam int c_VS_BEG = V_DISPLAY + V_FRONT;
    localparam int c_VS_END = c_VS_BEG + V_SYNC;

    localparam logic [c_CNT_W-1:0] c_H_LAST  = c_CNT_W'(c_H_TOT - 1);
    localparam logic [c_CNT_W-1:0] c_V_LAST  = c_CNT_W'(c_V_TOT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_state_next;
    logic [c_CNT_W-1:0] r_pix_x;
    logic [c_CNT_W-1:0] r_pix_y;
    logic [c_CNT_W-1:0] w_x_next;
    logic [c_CNT_W-1:0] w_y_next;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;
    logic               w_tick;
    logic               w_tick_clear;
    logic               w_tick_run;
    logic               w_adv;
    logic               w_x_wrap;
    logic               w_y_wrap;
    logic               w_frame_wrap;

    // Divider is held cleared whenever the raster is (or is about to be) idle
    assign w_tick_clear = (w_state_next == c_ST_IDLE);
    assign w_tick_run   = (r_state != c_ST_IDLE);

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_clear    (w_tick_clear),
        .i_run      (w_tick_run),
        .o_pix_tick (w_tick)
    );

    always_comb begin
        w_adv        = (r_state != c_ST_IDLE) && w_tick;
        w_x_wrap     = (r_pix_x == c_H_LAST);
        w_y_wrap     = (r_pix_y == c_V_LAST);
        w_frame_wrap = w_adv && w_x_wrap && w_y_wrap;

        w_x_next = r_pix_x;
        w_y_next = r_pix_y;
        if (w_adv) begin
            w_x_next = w_x_wrap ? '0 : r_pix_x + c_CNT_ONE;
            if (w_x_wrap) begin
                w_y_next = w_y_wrap ? '0 : r_pix_y + c_CNT_ONE;
            end
        end

        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (Enable) w_state_next = c_ST_RUN;
            c_ST_RUN:   if (!Enable) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: begin
                if (Enable)            w_state_next = c_ST_RUN;
                else if (w_frame_wrap) w_state_next = c_ST_IDLE;
            end
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Sync/blank decode uses next-counter values so it lines up with Pix_x/Pix_y
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state    <= c_ST_IDLE;
            r_pix_x    <= '0;
            r_pix_y    <= '0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pix_x <= w_x_next;
            r_pix_y <= w_y_next;
            if (w_state_next == c_ST_IDLE) begin
                r_hsync    <= 1'b1;
                r_vsync    <= 1'b1;
                r_video_on <= 1'b0;
            end else begin
                r_hsync    <= !((int'(w_x_next) >= c_HS_BEG) && (int'(w_x_next) < c_HS_END));
                r_vsync    <= !((int'(w_y_next) >= c_VS_BEG) && (int'(w_y_next) < c_VS_END));
                r_video_on <= (int'(w_x_next) < H_DISPLAY) && (int'(w_y_next) < V_DISPLAY);
            end
        end
    end

    assign Busy        = (r_state != c_ST_IDLE);
    assign Pix_tick    = w_tick;
    assign Pix_x       = r_pix_x;
    assign Pix_y       = r_pix_y;
    assign HSync       = r_hsync;
    assign VSync       = r_vsync;
    assign Video_on    = r_video_on;
    assign Frame_start = w_tick && (r_pix_x == '0) && (r_pix_y == '0) && (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Sequences the 640x480@60 VGA raster for the spirometer display from the single system clock. An internal pixel-enable (Pix_tick) replaces the toggled 25 MHz clock, so the whole design stays in one clock domain. The block generates the horizontal and vertical counters, sync pulses, blanking and frame markers. An Enable/Busy handshake starts the raster and stops it cleanly at a frame boundary.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1; 50 MHz/2 = 25 MHz pixel rate)
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_DISPLAY, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525

Ports:
Clk  in  1  system clock (50 MHz)
Rst  in  1  synchronous reset, active-low
Enable  in  1  level request to run the raster
Busy  out  1  high while state != IDLE
Pix_tick  out  1  one-Clk pulse per pixel period while running
Pix_x  out  10  horizontal counter, 0..H_TOTAL-1
Pix_y  out  10  vertical counter, 0..V_TOTAL-1
HSync  out  1  horizontal sync, active-low
VSync  out  1  vertical sync, active-low
Video_on  out  1  high when Pix_x < H_DISPLAY and Pix_y < V_DISPLAY
Frame_start  out  1  one-Clk pulse marking the first pixel of each frame

Behaviour:
- Reset (Rst==0 at a Clk edge, any state, mid-line included): state=IDLE, div counter=0, Pix_x=Pix_y=0, HSync=VSync=1, Video_on=0, Pix_tick=0, Frame_start=0, Busy=0.
- States:
  - IDLE: counters held at 0, syncs inactive (1), Pix_tick=0. Enable=1 -> RUN at next edge, div counter cleared.
  - RUN: Enable=0 -> DRAIN.
  - DRAIN: raster continues unchanged. Enable=1 -> RUN with no disturbance to counters or ticks. On the edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) -> IDLE; the counters land on (0,0).
- Pix_tick:
  - Div counter counts 0..CLK_DIV-1 in RUN/DRAIN; Pix_tick = (div==CLK_DIV-1), registered.
  - First Pix_tick occurs CLK_DIV cycles after leaving IDLE.
  - CLK_DIV=1: Pix_tick is constant 1 in RUN/DRAIN.
- Counters advance only on edges where Pix_tick=1:
  - Pix_x increments and wraps at H_TOTAL-1 -> 0.
  - Pix_y increments only when Pix_x wraps, and wraps at V_TOTAL-1 -> 0.
- Sync decode:
  - HSync=0 iff H_DISPLAY+H_FRONT <= Pix_x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - VSync=0 iff V_DISPLAY+V_FRONT <= Pix_y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
  - HSync, VSync and Video_on are registered from next-counter values, so they are cycle-aligned with Pix_x/Pix_y (zero skew between them).
- Frame_start=1 exactly in the Clk cycle where Pix_tick=1, Pix_x=0, Pix_y=0 and state != IDLE.
- Latency: every output changes at most once per pixel period, except Pix_tick and Frame_start, which are single-Clk pulses.
- Widths: counter width is 10 bits, fixed; H_TOTAL and V_TOTAL must be <= 1024.
- Simultaneous events: a Rst edge overrides Enable. An Enable change in the same cycle as the frame-wrap edge in DRAIN is evaluated against the current state: Enable=1 -> stays RUN; otherwise -> IDLE.

Decomposition:
- Shared package vga_timing_pkg:
  - 640x480 default timing constants and derived H_TOTAL/V_TOTAL.
  - State encoding IDLE/RUN/DRAIN.
  - Counter width constant (10).
- One sub-module, pix_tick_gen: parameterised CLK_DIV counter with synchronous clear and run input, output Pix_tick.

Test Plan:
- Reset values: hold Rst=0 for 5 cycles with Enable=1 -> all outputs at reset values, Busy=0. Release -> Busy=1 next cycle; first Pix_tick 2 cycles later.
- Line timing: run, CLK_DIV=2 -> HSync falling edges 1600 Clk apart, HSync low for 192 Clk, Video_on high for 1280 Clk per visible line.
- Frame timing: VSync falling edges 840000 Clk apart, VSync low for 3200 Clk. Frame_start pulses once per frame, with Pix_x=Pix_y=0.
- Graceful stop: drop Enable at (Pix_x=300, Pix_y=200) -> raster continues to (799,524); Busy falls after the wrap; counters read 0, HSync=VSync=1.
- DRAIN resume, then mid-line reset:
  - Drop Enable, then re-raise it at line 400 -> no gap in Pix_tick, next Frame_start exactly on schedule.
  - Rst=0 at Pix_x=700 (HSync low) -> HSync=1, counters 0 at the next edge.
- CLK_DIV=1 build: Pix_tick constant 1 in RUN; HSync period is 800 Clk.
